// File: rtl/uart_pkg.sv
// Shared encodings for the UART case-converter datapath: modes, ASCII constants, FSM states.
package uart_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UPPER  = 2'd0;
  localparam mode_t MODE_LOWER  = 2'd1;
  localparam mode_t MODE_TOGGLE = 2'd2;
  localparam mode_t MODE_PASS   = 2'd3;

  localparam logic [7:0] ASCII_U = 8'h55;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_P = 8'h50;

  localparam logic [7:0] UPPER_FIRST = 8'h41;
  localparam logic [7:0] UPPER_LAST  = 8'h5A;
  localparam logic [7:0] LOWER_FIRST = 8'h61;
  localparam logic [7:0] LOWER_LAST  = 8'h7A;
  localparam logic [7:0] CASE_BIT    = 8'h20;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POP  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_PUSH = 2'd3;

endpackage

// File: rtl/uart_case_map.sv
// Combinational ASCII case mapper; shared with the loopback test path.
module uart_case_map
  import uart_pkg::*;
(
  input  logic [7:0] i_byte,
  input  mode_t      i_mode,
  output logic [7:0] o_byte
);

  logic is_upper;
  logic is_lower;

  assign is_upper = (i_byte >= UPPER_FIRST) && (i_byte <= UPPER_LAST);
  assign is_lower = (i_byte >= LOWER_FIRST) && (i_byte <= LOWER_LAST);

  always_comb begin
    o_byte = i_byte;
    unique case (i_mode)
      MODE_UPPER:  if (is_lower) o_byte = i_byte - CASE_BIT;
      MODE_LOWER:  if (is_upper) o_byte = i_byte + CASE_BIT;
      MODE_TOGGLE: if (is_upper || is_lower) o_byte = i_byte ^ CASE_BIT;
      MODE_PASS:   o_byte = i_byte;
      default:     o_byte = i_byte;
    endcase
  end

endmodule

// File: rtl/uart_case_ctrl.sv
// Moves bytes from the RX FIFO to the TX FIFO through the case mapper, with an in-band
// escape protocol for selecting the mapping mode.
module uart_case_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  ESC_CHAR     = 8'h1B,
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_rx_rd_en,
  input  logic [7:0]       i_rx_rd_data,
  input  logic             i_rx_rd_valid,
  input  logic             i_rx_empty,
  output logic             o_tx_wr_en,
  output logic [7:0]       o_tx_wr_data,
  input  logic             i_tx_full,
  input  logic             i_tx_almostfull,
  output logic [1:0]       o_mode,
  output logic             o_busy,
  output logic             o_cmd_err,
  output logic [CNT_W-1:0] o_char_count
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             esc_q, esc_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_err;
  logic             can_pop;
  logic [7:0]       mapped;

  uart_case_map u_case_map (
    .i_byte (i_rx_rd_data),
    .i_mode (mode_q),
    .o_byte (mapped)
  );

  // almost-full only gates new pops; an in-flight byte always reaches PUSH
  assign can_pop = !i_rx_empty && !i_tx_almostfull;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    esc_d   = esc_q;
    hold_d  = hold_q;
    count_d = count_q;
    cmd_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (can_pop) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (i_rx_rd_valid) begin
          if (!esc_q) begin
            if (i_rx_rd_data == ESC_CHAR) begin
              esc_d = 1'b1;
            end else begin
              hold_d  = mapped;
              state_d = ST_PUSH;
            end
          end else begin
            esc_d = 1'b0;
            if (i_rx_rd_data == ASCII_U) begin
              mode_d = MODE_UPPER;
            end else if (i_rx_rd_data == ASCII_L) begin
              mode_d = MODE_LOWER;
            end else if (i_rx_rd_data == ASCII_T) begin
              mode_d = MODE_TOGGLE;
            end else if (i_rx_rd_data == ASCII_P) begin
              mode_d = MODE_PASS;
            end else if (i_rx_rd_data == ESC_CHAR) begin
              // doubled escape forwards one literal escape, unmapped
              hold_d  = ESC_CHAR;
              state_d = ST_PUSH;
            end else begin
              cmd_err = 1'b1;
            end
          end
        end
      end
      ST_PUSH: begin
        if (!i_tx_full) begin
          count_d = count_q + CNT_W'(1);
          state_d = can_pop ? ST_POP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= DEFAULT_MODE;
      esc_q   <= 1'b0;
      hold_q  <= 8'h00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      esc_q   <= esc_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  assign o_rx_rd_en   = (state_q == ST_POP);
  assign o_tx_wr_en   = (state_q == ST_PUSH) && !i_tx_full;
  assign o_tx_wr_data = hold_q;
  assign o_mode       = mode_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_cmd_err    = cmd_err;
  assign o_char_count = count_q;

endmodule

// File: tb/tb_uart_case_ctrl.sv
// Bench for uart_case_ctrl: behavioural FIFO models on both sides and a stream-level reference.
module tb_uart_case_ctrl;

  localparam int CNT_W = 8;
  localparam logic [7:0] ESC = 8'h1B;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             o_rx_rd_en;
  logic [7:0]       i_rx_rd_data = 8'h00;
  logic             i_rx_rd_valid = 1'b0;
  logic             i_rx_empty;
  logic             o_tx_wr_en;
  logic [7:0]       o_tx_wr_data;
  logic             i_tx_full = 1'b0;
  logic             i_tx_almostfull = 1'b0;
  logic [1:0]       o_mode;
  logic             o_busy;
  logic             o_cmd_err;
  logic [CNT_W-1:0] o_char_count;

  uart_case_ctrl #(
    .ESC_CHAR     (ESC),
    .DEFAULT_MODE (2'd0),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .o_rx_rd_en      (o_rx_rd_en),
    .i_rx_rd_data    (i_rx_rd_data),
    .i_rx_rd_valid   (i_rx_rd_valid),
    .i_rx_empty      (i_rx_empty),
    .o_tx_wr_en      (o_tx_wr_en),
    .o_tx_wr_data    (o_tx_wr_data),
    .i_tx_full       (i_tx_full),
    .i_tx_almostfull (i_tx_almostfull),
    .o_mode          (o_mode),
    .o_busy          (o_busy),
    .o_cmd_err       (o_cmd_err),
    .o_char_count    (o_char_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RX FIFO model: registered read data, valid one cycle after the strobe
  logic [7:0] rx_mem [0:4095];
  int rx_wr = 0;
  int rx_rd = 0;
  assign i_rx_empty = (rx_wr == rx_rd);

  always @(posedge i_clk) begin
    i_rx_rd_valid <= 1'b0;
    if (o_rx_rd_en && (rx_rd != rx_wr)) begin
      i_rx_rd_data  <= rx_mem[rx_rd % 4096];
      i_rx_rd_valid <= 1'b1;
      rx_rd         <= rx_rd + 1;
    end
  end

  // TX FIFO model plus event logs
  logic [7:0] tx_mem [0:4095];
  int tx_wr = 0;
  int tx_chk = 0;
  int cyc = 0;
  int pops = 0;
  int err_cnt = 0;
  int viol = 0;
  int wr_cyc [0:4095];
  int pop_cyc [0:4095];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_tx_wr_en) begin
      tx_mem[tx_wr % 4096] <= o_tx_wr_data;
      wr_cyc[tx_wr % 4096] <= cyc;
      tx_wr <= tx_wr + 1;
      if (i_tx_full) viol <= viol + 1;
    end
    if (o_rx_rd_en) begin
      pop_cyc[pops % 4096] <= cyc;
      pops <= pops + 1;
      if (i_rx_empty) viol <= viol + 1;
    end
    if (o_cmd_err) err_cnt <= err_cnt + 1;
  end

  // Stream-level reference model
  logic [1:0] m_mode = 2'd0;
  bit         m_esc = 1'b0;
  int         m_cnt = 0;
  int         m_err = 0;
  logic [7:0] exp_q [$];

  function automatic logic [7:0] ref_map(input logic [7:0] b, input logic [1:0] mode);
    bit up = (b >= 8'h41) && (b <= 8'h5A);
    bit lo = (b >= 8'h61) && (b <= 8'h7A);
    case (mode)
      2'd0:    return lo ? b - 8'h20 : b;
      2'd1:    return up ? b + 8'h20 : b;
      2'd2:    return (up || lo) ? (b ^ 8'h20) : b;
      default: return b;
    endcase
  endfunction

  task automatic rx_put(input logic [7:0] b);
    rx_mem[rx_wr % 4096] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_put(b);
    if (!m_esc) begin
      if (b == ESC) m_esc = 1'b1;
      else begin
        exp_q.push_back(ref_map(b, m_mode));
        m_cnt++;
      end
    end else begin
      m_esc = 1'b0;
      case (b)
        8'h55:   m_mode = 2'd0;
        8'h4C:   m_mode = 2'd1;
        8'h54:   m_mode = 2'd2;
        8'h50:   m_mode = 2'd3;
        ESC: begin
          exp_q.push_back(ESC);
          m_cnt++;
        end
        default: m_err++;
      endcase
    end
  endtask

  task automatic next_tx(output logic [7:0] b, output bit ok);
    ok = (tx_chk < tx_wr);
    b  = ok ? tx_mem[tx_chk % 4096] : 8'hxx;
    if (ok) tx_chk++;
  endtask

  task automatic drain(input string name);
    int k = 0;
    @(negedge i_clk);
    while ((!i_rx_empty || o_busy) && k < 3000) begin
      @(negedge i_clk);
      k++;
    end
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s drain: still busy after %0d cycles, required idle", name, k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if ({o_rx_rd_en, o_tx_wr_en, o_tx_wr_data, o_mode, o_busy, o_cmd_err, o_char_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rd=%b wr=%b data=%h mode=%0d busy=%b err=%b cnt=%0d, required all 0",
               o_rx_rd_en, o_tx_wr_en, o_tx_wr_data, o_mode, o_busy, o_cmd_err, o_char_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] a, e;
    bit ok;
    int p0 = pops;
    int w0 = tx_wr;
    send(8'h61); send(8'h42); send(8'h31);
    drain("basic");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_tx(a, ok);
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++;
        $display("FAIL basic_data: got %h (present=%0d), required %h", a, ok, e);
      end
    end
    n_checks++;
    if (o_char_count !== 8'd3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, required 3", o_char_count);
    end
    // POP, WAIT, PUSH: write lands two edges after the pop edge
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_cyc[w0 + i] - pop_cyc[p0 + i] !== 2) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: pop-to-write %0d edges, required 2", i,
                 wr_cyc[w0 + i] - pop_cyc[p0 + i]);
      end
    end
    n_checks++;
    if (wr_cyc[w0 + 2] - wr_cyc[w0 + 1] !== 3) begin
      n_fail++;
      $display("FAIL basic_rate: write spacing %0d, required 3", wr_cyc[w0 + 2] - wr_cyc[w0 + 1]);
    end
  endtask

  task automatic test_escape();
    logic [7:0] a, e;
    bit ok;
    string s = "HeLLo";
    send(ESC); send(8'h4C);
    for (int i = 0; i < 5; i++) send(s[i]);
    drain("escape_mode");
    n_checks++;
    if (o_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL escape_mode: mode %0d, required 1", o_mode);
    end
    send(ESC); send(ESC);
    send(ESC); send(8'h58);
    drain("escape_literal");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_tx(a, ok);
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++;
        $display("FAIL escape_data: got %h (present=%0d), required %h", a, ok, e);
      end
    end
    n_checks++;
    if (tx_chk !== tx_wr) begin
      n_fail++;
      $display("FAIL escape_extra: %0d unexpected writes, required 0", tx_wr - tx_chk);
    end
    n_checks++;
    if (err_cnt !== m_err || o_mode !== m_mode) begin
      n_fail++;
      $display("FAIL escape_err: err pulses %0d mode %0d, required %0d mode %0d",
               err_cnt, o_mode, m_err, m_mode);
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] a, e;
    bit ok;
    @(negedge i_clk);
    i_tx_full = 1'b1;
    send(8'h71);
    e = exp_q[0];
    repeat (4) @(negedge i_clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_tx_wr_en !== 1'b0 || o_busy !== 1'b1 || o_tx_wr_data !== e) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: wr=%b busy=%b data=%h, required wr=0 busy=1 data=%h",
                 i, o_tx_wr_en, o_busy, o_tx_wr_data, e);
      end
      @(negedge i_clk);
    end
    i_tx_full = 1'b0;
    #1;
    n_checks++;
    if (o_tx_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: wr=%b, required 1", o_tx_wr_en);
    end
    drain("tx_full");
    e = exp_q.pop_front();
    next_tx(a, ok);
    n_checks++;
    if (!ok || a !== e || tx_chk !== tx_wr) begin
      n_fail++;
      $display("FAIL full_data: got %h present=%0d extra=%0d, required %h once", a, ok,
               tx_wr - tx_chk, e);
    end
  endtask

  task automatic test_almostfull_toggle();
    logic [7:0] a, e;
    bit ok;
    int p0;
    @(negedge i_clk);
    i_tx_almostfull = 1'b1;
    p0 = pops;
    send(ESC); send(8'h54); send(8'hFF); send(8'h7A);
    repeat (10) @(negedge i_clk);
    n_checks++;
    if (pops !== p0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL almostfull_block: %0d pops busy=%b, required 0 pops busy=0", pops - p0, o_busy);
    end
    i_tx_almostfull = 1'b0;
    drain("toggle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_tx(a, ok);
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++;
        $display("FAIL toggle_data: got %h (present=%0d), required %h", a, ok, e);
      end
    end
    n_checks++;
    if (o_mode !== 2'd2) begin
      n_fail++;
      $display("FAIL toggle_mode: mode %0d, required 2", o_mode);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, e, b;
    bit ok;
    int k = 0;
    logic [7:0] pool [0:7] = '{ESC, 8'h55, 8'h4C, 8'h54, 8'h50, 8'h58, 8'h61, 8'h5A};
    for (int i = 0; i < 200; i++) begin
      b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      send(b);
    end
    while ((!i_rx_empty || o_busy) && k < 5000) begin
      @(negedge i_clk);
      i_tx_full       = ($urandom_range(0, 3) == 0);
      i_tx_almostfull = ($urandom_range(0, 3) == 0);
      k++;
    end
    i_tx_full = 1'b0;
    i_tx_almostfull = 1'b0;
    drain("random");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_tx(a, ok);
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++;
        $display("FAIL random_data: got %h (present=%0d), required %h", a, ok, e);
      end
    end
    n_checks++;
    if (tx_chk !== tx_wr || o_char_count !== m_cnt[CNT_W-1:0] || err_cnt !== m_err
        || o_mode !== m_mode) begin
      n_fail++;
      $display("FAIL random_state: extra=%0d cnt=%0d err=%0d mode=%0d, required 0 %0d %0d %0d",
               tx_wr - tx_chk, o_char_count, err_cnt, o_mode, m_cnt[CNT_W-1:0], m_err, m_mode);
    end
  endtask

  task automatic test_wrap();
    while ((m_cnt % (1 << CNT_W)) != (1 << CNT_W) - 1) send(8'h2E);
    drain("wrap_fill");
    n_checks++;
    if (o_char_count !== {CNT_W{1'b1}}) begin
      n_fail++;
      $display("FAIL wrap_full: count %0d, required all ones", o_char_count);
    end
    send(8'h2E);
    drain("wrap");
    n_checks++;
    if (o_char_count !== '0) begin
      n_fail++;
      $display("FAIL wrap_zero: count %0d, required 0", o_char_count);
    end
    tx_chk = tx_wr;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    bit ok;
    int p0;
    int k = 0;
    send(ESC); send(8'h4C);
    send(ESC);
    drain("reset_prep");
    p0 = pops;
    rx_put(8'h55);
    while (pops == p0 && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_rx_rd_en, o_tx_wr_en, o_tx_wr_data, o_mode, o_busy, o_cmd_err, o_char_count} !== '0
        || k >= 50) begin
      n_fail++;
      $display("FAIL reset_mid: rd=%b wr=%b data=%h mode=%0d busy=%b err=%b cnt=%0d, required all 0",
               o_rx_rd_en, o_tx_wr_en, o_tx_wr_data, o_mode, o_busy, o_cmd_err, o_char_count);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    m_mode = 2'd0; m_esc = 1'b0; m_cnt = 0;
    exp_q.delete();
    tx_chk = tx_wr;
    send(8'h55);
    drain("reset_after");
    next_tx(a, ok);
    n_checks++;
    if (!ok || a !== 8'h55 || o_char_count !== 8'd1 || o_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_after: got %h present=%0d cnt=%0d mode=%0d, required 55 1 cnt=1 mode=0",
               a, ok, o_char_count, o_mode);
    end
    exp_q.delete();
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL protocol: %0d strobes while full/empty, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_tx_full();
    test_almostfull_toggle();
    test_random();
    test_wrap();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
